// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared types and constants for the instruction fetch stage.
//   XLEN             : machine word / PC width
//   RESET_PC_DEFAULT : default first fetch PC
//   fetch_entry_t    : one buffered instruction together with its PC
//   pc_next()        : sequential PC step (modulo 2^XLEN)
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Plain 32-bit add, so 32'hFFFF_FFFC steps to 0.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the fetch stage's neighbours: branch-unit redirect, imem request /
//   response channels and the decode-side instruction channel.
//   modport master : fetch_unit view
//   modport slave  : environment view (branch unit + imem + decode)
//   With FETCH_MISALIGN_CHECK_EN defined, fetch_misaligned is carried too.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic            fetch_misaligned;

    modport master (
        input  redirect_valid, redirect_target, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
               fetch_misaligned
    );
    modport slave (
        output redirect_valid, redirect_target, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
               fetch_misaligned
    );
`else
    modport master (
        input  redirect_valid, redirect_target, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
    );
    modport slave (
        output redirect_valid, redirect_target, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
    );
`endif

endinterface

// File: rtl/fetch_unit_buffer.sv
// -----------------------------------------------------------------------------
// fetch_unit_buffer
//   Registered FIFO of fetch_entry_t between imem responses and decode.
//   No bypass: a push is visible at the head the cycle after.
//   clk, reset   : clock, synchronous active-high reset
//   push_i/data_i: enqueue (caller guarantees space, or a same-cycle pop)
//   pop_i        : dequeue head (caller guarantees non-empty)
//   flush_i      : drop all entries; wins over push/pop
//   head_o       : head entry, zero when empty
//   count_o      : occupancy
// -----------------------------------------------------------------------------
module fetch_unit_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output fetch_entry_t       head_o,
    output logic [CNT_W-1:0]   count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i)
            mem_q[wr_ptr_q] <= push_data_i;
    end

    // DEPTH is a power of two, so pointers wrap by overflow.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage: owns the PC, issues word requests to imem,
//   buffers returned instructions for decode, and restarts on a branch
//   redirect while discarding responses to fetches already in flight.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_unit_if.master (redirect, imem req/rsp, decode channel)
//   Build option FETCH_MISALIGN_CHECK_EN: a redirect to a non-word-aligned
//   target raises sticky fetch_misaligned and halts issue until the next
//   aligned redirect or reset. Without it the target's low two bits are
//   cleared before use.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH       = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int BCNT_W = $clog2(BUF_DEPTH + 1);

    // live: in flight and wanted; drop: in flight but killed by a redirect.
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  live_cnt_q, live_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [XLEN-1:0]   tgt;
    logic              issue_block;
    logic [31:0]       credit_used, inflight;
    logic              req_valid, req_fire;
    logic              rsp_drop, rsp_live;
    logic              buf_push, buf_pop;
    fetch_entry_t      buf_head, push_entry;
    logic [BCNT_W-1:0] buf_cnt;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q;

    assign tgt         = bus.redirect_target;
    assign issue_block = misaligned_q;

    always_ff @(posedge clk) begin
        if (reset)
            misaligned_q <= 1'b0;
        else if (bus.redirect_valid)
            misaligned_q <= (bus.redirect_target[1:0] != 2'b00);
    end

    assign bus.fetch_misaligned = misaligned_q;
`else
    assign tgt         = {bus.redirect_target[XLEN-1:2], 2'b00};
    assign issue_block = 1'b0;
`endif

    // Every live request already owns a buffer slot, so a response can
    // always be sunk even though imem has no backpressure.
    assign credit_used = 32'(live_cnt_q) + 32'(buf_cnt);
    assign inflight    = 32'(live_cnt_q) + 32'(drop_cnt_q);

    assign req_valid = !reset && !bus.redirect_valid && !issue_block
                    && (credit_used < 32'(BUF_DEPTH))
                    && (inflight < 32'(MAX_OUTSTANDING));
    assign req_fire  = req_valid && bus.imem_req_ready;

    // Responses are in order, so killed ones always come first.
    assign rsp_drop = bus.imem_rsp_valid && (drop_cnt_q != '0);
    assign rsp_live = bus.imem_rsp_valid && (drop_cnt_q == '0);

    assign buf_push   = rsp_live && !bus.redirect_valid;
    assign buf_pop    = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    assign push_entry = '{inst: bus.imem_rsp_data, pc: rsp_pc_q};

    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        live_cnt_d = live_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.redirect_valid) begin
            pc_d       = tgt;
            rsp_pc_d   = tgt;
            live_cnt_d = '0;
            // A response landing now is discarded whether it was live or
            // already dropped, so it comes off the combined total.
            drop_cnt_d = drop_cnt_q + live_cnt_q - CNT_W'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) pc_d     = pc_next(pc_q);
            if (rsp_live) rsp_pc_d = pc_next(rsp_pc_q);
            live_cnt_d = live_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
            drop_cnt_d = drop_cnt_q - CNT_W'(rsp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            live_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            live_cnt_q <= live_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_unit_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (buf_push),
        .push_data_i (push_entry),
        .pop_i       (buf_pop),
        .flush_i     (bus.redirect_valid),
        .head_o      (buf_head),
        .count_o     (buf_cnt)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = (buf_cnt != '0);
    assign bus.inst           = buf_head.inst;
    assign bus.inst_pc        = buf_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Randomised bench for fetch_unit with a queue-level reference model:
//   outstanding fetches are a queue of {addr, killed}, the instruction buffer
//   is a queue of {inst, pc}, and imem is a fixed-latency in-order echo whose
//   data is a hash of the address (latency 0 = same-cycle response).
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          BUF_DEPTH = 2;
    localparam int          MAX_OUT   = 2;
    localparam logic [31:0] RST_PC    = 32'h0000_0000;

    typedef struct { logic [31:0] addr; bit dropped; } ost_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    logic clk = 1'b0;
    logic reset;
    fetch_unit_if bus();

    int checks = 0, failures = 0, cyc = 0;
    int lat = 0, lat_next = 0;

    // stimulus for the next step
    logic        rst_in = 1'b0, redir_in = 1'b0, rdy_in = 1'b0, irdy_in = 1'b0;
    logic [31:0] tgt_in = '0;

    // reference model state
    ost_t        ost[$];
    ent_t        mbuf[$];
    pend_t       pend[$];
    logic [31:0] mpc = RST_PC;
    bit          mmis = 1'b0;

    // imem echo
    logic        rsp_v_q = 1'b0;
    logic [31:0] rsp_d_q = '0;

    // pcs decode actually took from the DUT
    logic [31:0] dut_dlv[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.imem_rsp_valid = (lat == 0) ? (bus.imem_req_valid & bus.imem_req_ready) : rsp_v_q;
    assign bus.imem_rsp_data  = (lat == 0) ? memfn(bus.imem_req_addr) : rsp_d_q;

    fetch_unit #(
        .RESET_PC        (RST_PC),
        .BUF_DEPTH       (BUF_DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int live_count();
        int n = 0;
        foreach (ost[i]) if (!ost[i].dropped) n++;
        return n;
    endfunction

    function automatic int drop_count();
        return ost.size() - live_count();
    endfunction

    function automatic logic [31:0] dlv_at(input int i);
        if (i < dut_dlv.size()) return dut_dlv[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic model_reset();
        mpc  = RST_PC;
        mmis = 1'b0;
        ost.delete();
        mbuf.delete();
        pend.delete();
    endtask

    // One clock: drive at negedge, compare 1 time unit later, advance model.
    task automatic step();
        bit   exp_req, fire, rsp, pop;
        ost_t h;
        @(negedge clk);
        cyc++;
        lat   = lat_next;
        reset = rst_in;
        bus.redirect_valid  = redir_in;
        bus.redirect_target = tgt_in;
        bus.imem_req_ready  = rdy_in;
        bus.inst_ready      = irdy_in;
        if (lat > 0 && !rst_in && pend.size() > 0 && pend[0].due <= cyc) begin
            rsp_v_q = 1'b1;
            rsp_d_q = memfn(pend[0].addr);
        end else begin
            rsp_v_q = 1'b0;
            rsp_d_q = '0;
        end
        #1;
        exp_req = !rst_in && !redir_in && !mmis
               && (live_count() + mbuf.size() < BUF_DEPTH)
               && (ost.size() < MAX_OUT);
        chk("req_valid", {31'd0, bus.imem_req_valid}, {31'd0, exp_req});
        chk("req_addr", bus.imem_req_addr, mpc);
        chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, mbuf.size() > 0});
        if (mbuf.size() > 0) begin
            chk("inst", bus.inst, mbuf[0].inst);
            chk("inst_pc", bus.inst_pc, mbuf[0].pc);
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("misaligned", {31'd0, bus.fetch_misaligned}, {31'd0, mmis});
`endif
        if (!rst_in && !redir_in && bus.inst_valid && irdy_in)
            dut_dlv.push_back(bus.inst_pc);

        if (rst_in) begin
            model_reset();
            return;
        end

        fire = exp_req && rdy_in;
        if (fire) begin
            ost.push_back('{addr: mpc, dropped: 1'b0});
            if (lat > 0) pend.push_back('{addr: mpc, due: cyc + lat});
            mpc = mpc + 32'd4;
        end
        rsp = (lat == 0) ? fire : rsp_v_q;
        if (lat > 0 && rsp_v_q) pend.pop_front();

        pop = !redir_in && irdy_in && mbuf.size() > 0;
        if (pop) mbuf.pop_front();

        if (rsp) begin
            if (ost.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_without_request: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                h = ost.pop_front();
                if (!h.dropped && !redir_in)
                    mbuf.push_back('{inst: memfn(h.addr), pc: h.addr});
            end
        end

        if (redir_in) begin
            mbuf.delete();
            foreach (ost[i]) begin
                h = ost[i];
                h.dropped = 1'b1;
                ost[i] = h;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            mpc  = tgt_in;
            mmis = (tgt_in[1:0] != 2'b00);
`else
            mpc  = {tgt_in[31:2], 2'b00};
`endif
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redir_in = 1'b1;
        tgt_in   = t;
        step();
        redir_in = 1'b0;
    endtask

    // Let every pending imem response drain before changing latency.
    task automatic set_lat(input int l);
        rdy_in = 1'b0;
        run(6);
        lat_next = l;
        rdy_in = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nreq;
        bit  found;
        reset = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.imem_req_ready  = 1'b0;
        bus.inst_ready      = 1'b0;
        @(posedge clk);

        // reset state
        rst_in = 1'b1;
        run(2);
        rst_in = 1'b0;

        // 1: zero-wait imem, decode always ready -> one instruction per cycle
        rdy_in = 1'b1;
        irdy_in = 1'b1;
        run(8);
        chk("t1_count", dut_dlv.size(), 7);
        chk("t1_pc0", dlv_at(0), 32'h0);
        chk("t1_pc1", dlv_at(1), 32'h4);
        chk("t1_pc2", dlv_at(2), 32'h8);

        // 2: decode stalls -> buffer fills, issue stops, nothing lost on resume
        irdy_in = 1'b0;
        run(10);
        chk("t2_req_stalled", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("t2_buf_full", mbuf.size(), BUF_DEPTH);
        irdy_in = 1'b1;
        run(6);
        chk("t2_count", dut_dlv.size(), 13);
        foreach (dut_dlv[i]) chk("t2_seq", dut_dlv[i], 32'(i) * 32'd4);

        // 3: 2-cycle imem, two live, redirect kills both
        set_lat(2);
        for (int i = 0; i < 10 && live_count() < 2; i++) step();
        chk("t3_two_live", live_count(), 2);
        redirect_to(32'h100);
        dut_dlv.delete();
        run(12);
        chk("t3_first", dlv_at(0), 32'h100);
        chk("t3_second", dlv_at(1), 32'h104);
        chk("t3_drop_zero", 32'(dut.drop_cnt_q), 32'd0);
        chk("t3_model_drop", drop_count(), 0);

        // 4: redirect together with a response arrival and a decode pop
        set_lat(1);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pend.size() > 0 && pend[0].due <= cyc + 1 && mbuf.size() > 0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("t4_setup", {31'd0, found}, 32'd1);
        redirect_to(32'h300);
        chk("t4_rsp_same_cycle", {31'd0, bus.imem_rsp_valid}, 32'd1);
        chk("t4_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("t4_flushed", {31'd0, bus.inst_valid}, 32'd0);
        run(8);

        // 5: back-to-back redirects, only the second stream survives
        set_lat(2);
        run(4);
        redirect_to(32'h40);
        redirect_to(32'h80);
        dut_dlv.delete();
        run(12);
        chk("t5_first", dlv_at(0), 32'h80);
        chk("t5_second", dlv_at(1), 32'h84);

        // 6: misaligned redirect
`ifdef FETCH_MISALIGN_CHECK_EN
        redirect_to(32'h102);
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.imem_req_valid) nreq++;
        end
        chk("t6_trap", {31'd0, bus.fetch_misaligned}, 32'd1);
        chk("t6_no_issue", nreq, 0);
        redirect_to(32'h200);
        dut_dlv.delete();
        run(10);
        chk("t6_cleared", {31'd0, bus.fetch_misaligned}, 32'd0);
        chk("t6_resume", dlv_at(0), 32'h200);
`else
        nreq = 0;
        redirect_to(32'h206);
        dut_dlv.delete();
        run(10);
        chk("t6_aligned", dlv_at(0), 32'h204);
`endif

        // PC wrap
        set_lat(0);
        redirect_to(32'hFFFF_FFF8);
        dut_dlv.delete();
        run(8);
        chk("wrap0", dlv_at(0), 32'hFFFF_FFF8);
        chk("wrap1", dlv_at(1), 32'hFFFF_FFFC);
        chk("wrap2", dlv_at(2), 32'h0000_0000);
        chk("wrap3", dlv_at(3), 32'h0000_0004);

        // randomised traffic
        for (int blk = 0; blk < 12; blk++) begin
            set_lat(int'($urandom_range(0, 3)));
            for (int i = 0; i < 250; i++) begin
                int r;
                rst_in   = ($urandom_range(0, 399) == 0);
                rdy_in   = ($urandom_range(0, 3) != 0);
                irdy_in  = ($urandom_range(0, 9) < 7);
                redir_in = ($urandom_range(0, 99) < 5);
                r = int'($urandom_range(0, 7));
                if (r == 0)      tgt_in = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                else if (r == 1) tgt_in = $urandom & 32'hFFFF;
                else             tgt_in = $urandom & 32'hFFFC;
                step();
            end
            rst_in = 1'b0;
            redir_in = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
